// File: rtl/atm_session_ctrl.sv
// Session sequencer for the card/PIN/withdraw flow: owns balance, failed-PIN
// count, inactivity timer and lockout; every update is qualified by the prescaler tick.
module atm_session_ctrl #(
    parameter int TIMEOUT_TICKS  = 10,
    parameter int MAX_TRIES      = 3,
    parameter int INIT_BALANCE   = 1000,
    parameter int BAL_W          = 12,
    parameter int DISPENSE_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             card_in,
    input  logic             pin_enter,
    input  logic             pin_match,
    input  logic             withdraw_req,
    input  logic [1:0]       amt_sel,
    input  logic             cancel,
    output logic             auth_ok,
    output logic             pin_fail,
    output logic             locked,
    output logic             dispense,
    output logic [3:0]       q_sel,
    output logic             no_money,
    output logic [BAL_W-1:0] balance,
    output logic [2:0]       state_dbg
);

    localparam int CNT_MAX = (TIMEOUT_TICKS > DISPENSE_TICKS) ? TIMEOUT_TICKS : DISPENSE_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_PIN = 3'd1,
        S_CHECK    = 3'd2,
        S_MENU     = 3'd3,
        S_DISPENSE = 3'd4,
        S_LOCKED   = 3'd5
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_timer, w_timer_inc, w_timer_nxt;
    logic [TRY_W-1:0]   r_tries, w_tries_inc;
    logic [BAL_W-1:0]   r_balance, w_amount;
    logic [3:0]         r_q_sel, w_q_sel_nxt;
    logic               r_auth_ok, r_pin_fail, r_locked, r_dispense, r_no_money;
    logic               w_auth_nxt, w_locked_nxt, w_dispense_nxt;
    logic               w_abort, w_tmo, w_pin_good, w_pin_bad, w_wd_ok, w_wd_rej;

    assign w_amount    = BAL_W'((9'(amt_sel) + 9'd1) * 9'd100);
    assign w_timer_inc = r_timer + CNT_W'(1);
    assign w_tries_inc = r_tries + TRY_W'(1);
    assign w_abort     = !card_in || cancel;
    assign w_tmo       = (w_timer_inc == CNT_W'(TIMEOUT_TICKS));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else if (tick) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort beats timeout beats the normal action in WAIT_PIN/MENU
    always_comb begin
        w_state_nxt = r_state;
        w_pin_good  = 1'b0;
        w_pin_bad   = 1'b0;
        w_wd_ok     = 1'b0;
        w_wd_rej    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (card_in) w_state_nxt = S_WAIT_PIN;
                else         w_state_nxt = S_IDLE;
            end
            S_WAIT_PIN: begin
                if (w_abort || w_tmo) w_state_nxt = S_IDLE;
                else if (pin_enter)   w_state_nxt = S_CHECK;
                else                  w_state_nxt = S_WAIT_PIN;
            end
            S_CHECK: begin
                if (pin_match) begin
                    w_pin_good  = 1'b1;
                    w_state_nxt = S_MENU;
                end else begin
                    w_pin_bad   = 1'b1;
                    if (w_tries_inc == TRY_W'(MAX_TRIES)) w_state_nxt = S_LOCKED;
                    else                                  w_state_nxt = S_WAIT_PIN;
                end
            end
            S_MENU: begin
                if (w_abort || w_tmo) begin
                    w_state_nxt = S_IDLE;
                end else if (withdraw_req) begin
                    if (w_amount <= r_balance) begin
                        w_wd_ok     = 1'b1;
                        w_state_nxt = S_DISPENSE;
                    end else begin
                        w_wd_rej    = 1'b1;
                        w_state_nxt = S_MENU;
                    end
                end else begin
                    w_state_nxt = S_MENU;
                end
            end
            S_DISPENSE: begin
                if (w_timer_inc == CNT_W'(DISPENSE_TICKS)) w_state_nxt = S_MENU;
                else                                       w_state_nxt = S_DISPENSE;
            end
            S_LOCKED: w_state_nxt = S_LOCKED;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output/timer next values; the timer doubles as the dispense hold counter
    always_comb begin
        w_auth_nxt     = (w_state_nxt == S_MENU) || (w_state_nxt == S_DISPENSE);
        w_locked_nxt   = (w_state_nxt == S_LOCKED);
        w_dispense_nxt = (w_state_nxt == S_DISPENSE);
        if (w_wd_ok)                       w_q_sel_nxt = 4'b0001 << amt_sel;
        else if (w_state_nxt == S_DISPENSE) w_q_sel_nxt = r_q_sel;
        else                                w_q_sel_nxt = 4'b0000;
        if (w_state_nxt != r_state || w_wd_rej) w_timer_nxt = '0;
        else if (r_state == S_WAIT_PIN || r_state == S_MENU || r_state == S_DISPENSE)
            w_timer_nxt = w_timer_inc;
        else
            w_timer_nxt = '0;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer    <= '0;
            r_tries    <= '0;
            r_balance  <= BAL_W'(INIT_BALANCE);
            r_q_sel    <= 4'b0000;
            r_auth_ok  <= 1'b0;
            r_pin_fail <= 1'b0;
            r_locked   <= 1'b0;
            r_dispense <= 1'b0;
            r_no_money <= 1'b0;
        end else if (tick) begin
            r_timer    <= w_timer_nxt;
            if (w_pin_good)     r_tries <= '0;
            else if (w_pin_bad) r_tries <= w_tries_inc;
            if (w_wd_ok)        r_balance <= r_balance - w_amount;
            r_q_sel    <= w_q_sel_nxt;
            r_auth_ok  <= w_auth_nxt;
            r_pin_fail <= w_pin_bad;
            r_locked   <= w_locked_nxt;
            r_dispense <= w_dispense_nxt;
            r_no_money <= w_wd_rej;
        end
    end

    assign auth_ok   = r_auth_ok;
    assign pin_fail  = r_pin_fail;
    assign locked    = r_locked;
    assign dispense  = r_dispense;
    assign q_sel     = r_q_sel;
    assign no_money  = r_no_money;
    assign balance   = r_balance;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed walk through the session flow followed by randomized ticks, all
// compared against a tick-level behavioural model of the ATM session.
module tb_atm_session_ctrl;

    localparam int T_TMO  = 10;
    localparam int T_MAXT = 3;
    localparam int T_INIT = 1000;
    localparam int T_BALW = 12;
    localparam int T_DTK  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0, card_in = 1'b0, pin_enter = 1'b0, pin_match = 1'b0;
    logic withdraw_req = 1'b0, cancel = 1'b0;
    logic [1:0] amt_sel = 2'd0;
    logic auth_ok, pin_fail, locked, dispense, no_money;
    logic [3:0] q_sel;
    logic [T_BALW-1:0] balance;
    logic [2:0] state_dbg;

    int checks = 0;
    int failures = 0;

    // model: state numbers follow the documented state_dbg values
    int m_state, m_bal, m_tries, m_idle, m_dleft, m_q;
    bit m_pf, m_nm;

    atm_session_ctrl #(.TIMEOUT_TICKS(T_TMO), .MAX_TRIES(T_MAXT), .INIT_BALANCE(T_INIT),
                       .BAL_W(T_BALW), .DISPENSE_TICKS(T_DTK)) dut (
        .clk(clk), .rst(rst), .tick(tick), .card_in(card_in), .pin_enter(pin_enter),
        .pin_match(pin_match), .withdraw_req(withdraw_req), .amt_sel(amt_sel),
        .cancel(cancel), .auth_ok(auth_ok), .pin_fail(pin_fail), .locked(locked),
        .dispense(dispense), .q_sel(q_sel), .no_money(no_money), .balance(balance),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_bal = T_INIT; m_tries = 0; m_idle = 0; m_dleft = 0; m_q = 0;
        m_pf = 1'b0; m_nm = 1'b0;
    endtask

    task automatic go(input int s);
        m_state = s;
        m_idle  = 0;
    endtask

    task automatic model_step();
        int amt;
        m_pf = 1'b0;
        m_nm = 1'b0;
        case (m_state)
            0: if (card_in) go(1);
            1: begin
                if (!card_in || cancel) go(0);
                else begin
                    m_idle++;
                    if (m_idle >= T_TMO) go(0);
                    else if (pin_enter) go(2);
                end
            end
            2: begin
                if (pin_match) begin
                    m_tries = 0;
                    go(3);
                end else begin
                    m_tries++;
                    m_pf = 1'b1;
                    go((m_tries == T_MAXT) ? 5 : 1);
                end
            end
            3: begin
                if (!card_in || cancel) go(0);
                else begin
                    m_idle++;
                    if (m_idle >= T_TMO) go(0);
                    else if (withdraw_req) begin
                        amt = (int'(amt_sel) + 1) * 100;
                        if (amt <= m_bal) begin
                            m_bal  -= amt;
                            m_q     = 1 << amt_sel;
                            m_dleft = T_DTK;
                            go(4);
                        end else begin
                            m_nm   = 1'b1;
                            m_idle = 0;
                        end
                    end
                end
            end
            4: begin
                m_dleft--;
                if (m_dleft == 0) go(3);
            end
            default: ;
        endcase
    endtask

    task automatic check_all(input string p);
        chk({p, ".state"},    32'(state_dbg), 32'(m_state));
        chk({p, ".balance"},  32'(balance),   32'(m_bal));
        chk({p, ".auth_ok"},  32'(auth_ok),   32'(m_state == 3 || m_state == 4));
        chk({p, ".locked"},   32'(locked),    32'(m_state == 5));
        chk({p, ".dispense"}, 32'(dispense),  32'(m_state == 4));
        chk({p, ".q_sel"},    32'(q_sel),     (m_state == 4) ? 32'(m_q) : 32'd0);
        chk({p, ".pin_fail"}, 32'(pin_fail),  32'(m_pf));
        chk({p, ".no_money"}, 32'(no_money),  32'(m_nm));
    endtask

    // one tick pulse after a random gap; outputs must be frozen across the gap
    task automatic do_tick();
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
        check_all("gap");
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        model_step();
        check_all("tick");
    endtask

    task automatic set_in(input bit c, input bit pe, input bit pm, input bit wd,
                          input int a, input bit cn);
        card_in = c; pin_enter = pe; pin_match = pm; withdraw_req = wd;
        amt_sel = 2'(a); cancel = cn;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic login(input bit match);
        set_in(1, 0, 0, 0, 0, 0); do_tick();
        set_in(1, 1, 0, 0, 0, 0); do_tick();
        set_in(1, 0, match, 0, 0, 0); do_tick();
        set_in(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("por");
        rst = 1'b1;
        @(negedge clk);

        // happy path: state 0 -> 1 -> 2 -> 3
        set_in(1, 0, 0, 0, 0, 0); do_tick(); chk("tp_wait", 32'(state_dbg), 32'd1);
        set_in(1, 1, 0, 0, 0, 0); do_tick(); chk("tp_check", 32'(state_dbg), 32'd2);
        set_in(1, 0, 1, 0, 0, 0); do_tick(); chk("tp_menu", 32'(state_dbg), 32'd3);
        chk("tp_auth", 32'(auth_ok), 32'd1);
        chk("tp_bal1000", 32'(balance), 32'd1000);

        // 400 withdrawal, dispense held two ticks
        set_in(1, 0, 0, 1, 3, 0); do_tick();
        chk("wd_q", 32'(q_sel), 32'd8);
        chk("wd_bal600", 32'(balance), 32'd600);
        set_in(1, 0, 0, 0, 0, 1); do_tick(); chk("wd_hold", 32'(dispense), 32'd1);
        set_in(1, 0, 0, 0, 0, 0); do_tick(); chk("wd_back", 32'(state_dbg), 32'd3);
        chk("wd_q0", 32'(q_sel), 32'd0);

        // second 400, then 300 against 200 is rejected
        set_in(1, 0, 0, 1, 3, 0); do_tick();
        set_in(1, 0, 0, 0, 0, 0); do_tick(); do_tick();
        chk("bal200", 32'(balance), 32'd200);
        set_in(1, 0, 0, 1, 2, 0); do_tick();
        chk("nm_pulse", 32'(no_money), 32'd1);
        chk("nm_state", 32'(state_dbg), 32'd3);
        set_in(1, 0, 0, 0, 0, 0); do_tick();
        chk("nm_clear", 32'(no_money), 32'd0);
        for (int k = 0; k < T_TMO - 2; k++) do_tick();
        chk("nm_timer_restart", 32'(state_dbg), 32'd3);

        // three failed sessions -> lockout
        set_in(0, 0, 0, 0, 0, 0); do_tick();
        for (int k = 0; k < 3; k++) begin
            login(1'b0);
            chk("pf_pulse", 32'(pin_fail), 32'd1);
            set_in(0, 0, 0, 0, 0, 0); do_tick();
        end
        chk("lk_locked", 32'(locked), 32'd1);
        chk("lk_state", 32'(state_dbg), 32'd5);
        set_in(1, 1, 1, 1, 0, 0); do_tick(); do_tick();
        chk("lk_stuck", 32'(state_dbg), 32'd5);
        do_reset();
        chk("lk_reset_bal", 32'(balance), 32'd1000);

        // inactivity timeout in WAIT_PIN at exactly TIMEOUT_TICKS
        set_in(1, 0, 0, 0, 0, 0); do_tick();
        for (int k = 0; k < T_TMO - 1; k++) do_tick();
        chk("to_wait_before", 32'(state_dbg), 32'd1);
        do_tick();
        chk("to_wait_idle", 32'(state_dbg), 32'd0);

        // same in MENU
        login(1'b1);
        for (int k = 0; k < T_TMO - 1; k++) do_tick();
        chk("to_menu_before", 32'(state_dbg), 32'd3);
        do_tick();
        chk("to_menu_idle", 32'(state_dbg), 32'd0);

        // cancel coinciding with timeout
        login(1'b1);
        for (int k = 0; k < T_TMO - 1; k++) do_tick();
        set_in(1, 0, 0, 1, 0, 1); do_tick();
        chk("cn_idle", 32'(state_dbg), 32'd0);
        chk("cn_bal", 32'(balance), 32'd1000);

        // asynchronous reset in the middle of a dispense
        set_in(1, 0, 0, 0, 0, 0); do_tick();
        login(1'b1);
        set_in(1, 0, 0, 1, 0, 0); do_tick();
        chk("md_disp", 32'(dispense), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("md_state", 32'(state_dbg), 32'd0);
        chk("md_disp0", 32'(dispense), 32'd0);
        chk("md_q0", 32'(q_sel), 32'd0);
        chk("md_bal", 32'(balance), 32'd1000);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // randomized ticks against the model
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            set_in($urandom_range(0, 99) < 90, $urandom_range(0, 99) < 35,
                   $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 40,
                   int'($urandom_range(0, 3)), $urandom_range(0, 99) < 4);
            do_tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
